uart_tx_arbiter: RTL

Round-robin scheduler that shares one UART transmitter among up to NUM_REQ byte-stream requesters (motor telemetry, status, debug). Each requester presents a message as a valid/ready byte stream terminated by a last flag. The arbiter grants one requester at a time and optionally prefixes each message with an ID header byte. The grant is held until the message's last byte is accepted, or until a stall watchdog fires. The arbiter's downstream port drives the transmitter's data_in / data_in_valid and receives its data_in_ready.

---
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte-stream
// requesters, with an optional per-message ID header and a stall watchdog.
module uart_tx_arbiter #(
  parameter int         NUM_REQ       = 4,
  parameter bit         HEADER_EN     = 1'b1,
  parameter logic [7:0] HEADER_BASE   = 8'hA0,
  parameter int         STALL_TIMEOUT = 1_000_000,
  localparam int        ID_W          = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 timeout_pulse
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HEADER = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  localparam int              CNT_W       = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
  localparam bit              WD_EN       = (STALL_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);

  logic [1:0]       state;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic [CNT_W-1:0] stall_cnt;
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;
  logic             xfer;

  // Round-robin search starting just after the previous owner.
  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
        winner = ID_W'((int'(last_grant) + k) % NUM_REQ);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    case (state)
      S_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = HEADER_BASE | 8'(grant_id);
      end
      S_STREAM: begin
        tx_valid = sel_valid;
        tx_data  = sel_data;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_id == ID_W'(i)) req_ready[i] = tx_ready;
        end
      end
      default: ;
    endcase
  end

  assign xfer          = (state == S_STREAM) && sel_valid && tx_ready;
  // A byte accepted on the limit cycle wins over the watchdog.
  assign timeout_pulse = WD_EN && (state == S_STREAM) && !xfer && (stall_cnt == STALL_LIMIT);
  assign busy          = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      stall_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_id  <= winner;
            state     <= HEADER_EN ? S_HEADER : S_STREAM;
            stall_cnt <= '0;
          end
        end
        S_HEADER: begin
          if (tx_ready) begin
            state     <= S_STREAM;
            stall_cnt <= '0;
          end
        end
        S_STREAM: begin
          if (xfer) begin
            stall_cnt <= '0;
            if (sel_last) begin
              last_grant <= grant_id;
              state      <= S_IDLE;
            end
          end else if (timeout_pulse) begin
            last_grant <= grant_id;
            state      <= S_IDLE;
            stall_cnt  <= '0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
